// File: rtl/mac_result_if.sv
// Result stream from mac_result_collector to the output buffer.
//   out_valid  head entry present
//   out_ready  consumer accepts the head this cycle
//   out_data   quantised result at the head
//   out_addr   output-feature-map address tagged to the head
// master = collector side, slave = output-buffer side.
interface mac_result_if #(
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/mac_result_collector.sv
// Consumer-side companion to the MAC control unit. Counts taps between
// window boundaries, captures and quantises the accumulator when a window
// ends with exactly TAPS taps, tags the result with an output address and
// queues it in a small FIFO drained over a valid/ready stream.
//   clk, rst          clock, asynchronous active-low reset
//   sel, mac_reset    control-unit strobes (sel==01 marks a tap)
//   mac_acc           signed accumulator, sampled in the window-end cycle
//   clr_err           clears the sticky flags at the next edge
//   res               result stream (master side)
//   count             FIFO occupancy
//   frame_done        pulse after the last address of a frame is queued
//   ovf, err_short    sticky: dropped capture, wrong tap count
//
// state  | meaning
// S_IDLE | between windows; mac_reset ignored, first tap starts a window
// S_ACC  | counting taps; mac_reset closes the window
module mac_result_collector #(
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 0,
  parameter int TAPS    = 3,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8,
  parameter int NUM_OUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               sel,
  input  logic                     mac_reset,
  input  logic signed [ACC_W-1:0]  mac_acc,
  input  logic                     clr_err,
  mac_result_if.master             res,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_done,
  output logic                     ovf,
  output logic                     err_short
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t            state_q, state_d;
  logic [3:0]        tap_cnt_q, tap_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q, ovf_d, err_short_q, err_short_d;
  logic [OUT_W-1:0]  last_data_q, last_data_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [OUT_W-1:0]  data_mem_q [DEPTH];
  logic [OUT_W-1:0]  data_mem_d [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];

  logic                    tap, window_end, push_req, push_ok, drop, pop, full, empty;
  logic                    addr_last;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        quant;

  assign tap        = (sel == 2'b01) && !mac_reset;
  assign window_end = (state_q == S_ACC) && mac_reset;
  assign push_req   = window_end && (tap_cnt_q == 4'(TAPS));
  assign empty      = (count_q == '0);
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign pop        = !empty && res.out_ready;
  // A full FIFO still accepts the capture when the head leaves in the same cycle.
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign addr_last  = (addr_q == ADDR_W'(NUM_OUT - 1));

  assign shifted = mac_acc >>> SHIFT;

  always_comb begin
    quant = shifted[OUT_W-1:0];
    if (shifted < 0)          quant = '0;
    else if (shifted > R_MAX) quant = '1;
  end

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tap) begin
          state_d   = S_ACC;
          tap_cnt_d = 4'd1;
        end
      end
      S_ACC: begin
        if (mac_reset) begin
          state_d   = S_IDLE;
          tap_cnt_d = '0;
        end else if (tap && tap_cnt_q != 4'd15) begin
          tap_cnt_d = tap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        tap_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    addr_d       = addr_q;
    data_mem_d   = data_mem_q;
    addr_mem_d   = addr_mem_q;
    last_data_d  = last_data_q;
    last_addr_d  = last_addr_q;
    frame_done_d = push_ok && addr_last;
    if (push_ok) begin
      data_mem_d[wr_ptr_q] = quant;
      addr_mem_d[wr_ptr_q] = addr_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
      addr_d               = addr_last ? '0 : addr_q + 1'b1;
    end
    if (pop) begin
      last_data_d = data_mem_q[rd_ptr_q];
      last_addr_d = addr_mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    // Set beats clear when both land in the same cycle.
    ovf_d       = drop ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    err_short_d = (window_end && !push_req) ? 1'b1 : (clr_err ? 1'b0 : err_short_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tap_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      err_short_q  <= 1'b0;
      last_data_q  <= '0;
      last_addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tap_cnt_q    <= tap_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      err_short_q  <= err_short_d;
      last_data_q  <= last_data_d;
      last_addr_q  <= last_addr_d;
      data_mem_q   <= data_mem_d;
      addr_mem_q   <= addr_mem_d;
    end
  end

  // Empty FIFO shows the most recently popped entry rather than a stale slot.
  assign res.out_valid = !empty;
  assign res.out_data  = empty ? last_data_q : data_mem_q[rd_ptr_q];
  assign res.out_addr  = empty ? last_addr_q : addr_mem_q[rd_ptr_q];
  assign count         = count_q;
  assign frame_done    = frame_done_q;
  assign ovf           = ovf_q;
  assign err_short     = err_short_q;
endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: a default instance, a NUM_OUT=4
// instance for frame wrap and a SHIFT=2 instance for quantisation, all on
// shared stimulus.
module tb_mac_result_collector;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [1:0]         sel = 2'b00;
  logic               mac_reset = 1'b0;
  logic signed [15:0] mac_acc = '0;
  logic               clr_err = 1'b0;
  logic               ready = 1'b0;

  logic [2:0] d_count, w_count, s_count;
  logic       d_fd, w_fd, s_fd, d_ovf, w_ovf, s_ovf, d_es, w_es, s_es;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  mac_result_if #(.OUT_W(8), .ADDR_W(8)) d_if ();
  mac_result_if #(.OUT_W(8), .ADDR_W(8)) w_if ();
  mac_result_if #(.OUT_W(8), .ADDR_W(8)) s_if ();
  assign d_if.out_ready = ready;
  assign w_if.out_ready = ready;
  assign s_if.out_ready = ready;

  mac_result_collector u_dut (
    .clk(clk), .rst(rst), .sel(sel), .mac_reset(mac_reset), .mac_acc(mac_acc),
    .clr_err(clr_err), .res(d_if.master), .count(d_count), .frame_done(d_fd),
    .ovf(d_ovf), .err_short(d_es));

  mac_result_collector #(.NUM_OUT(4)) u_wrap (
    .clk(clk), .rst(rst), .sel(sel), .mac_reset(mac_reset), .mac_acc(mac_acc),
    .clr_err(clr_err), .res(w_if.master), .count(w_count), .frame_done(w_fd),
    .ovf(w_ovf), .err_short(w_es));

  mac_result_collector #(.SHIFT(2)) u_shift (
    .clk(clk), .rst(rst), .sel(sel), .mac_reset(mac_reset), .mac_acc(mac_acc),
    .clr_err(clr_err), .res(s_if.master), .count(s_count), .frame_done(s_fd),
    .ovf(s_ovf), .err_short(s_es));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (w_fd) fd_cnt++;
  endtask

  task automatic idle();
    sel = 2'b00; mac_reset = 1'b0; clr_err = 1'b0;
    tick();
  endtask

  task automatic taps(input int n);
    for (int i = 0; i < n; i++) begin
      sel = 2'b01; mac_reset = 1'b0;
      tick();
    end
    sel = 2'b00;
  endtask

  task automatic end_window(input int acc);
    sel = 2'b00; mac_reset = 1'b1; mac_acc = 16'(acc);
    tick();
    mac_reset = 1'b0;
  endtask

  task automatic do_reset();
    sel = 2'b00; mac_reset = 1'b0; clr_err = 1'b0; ready = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  int nom_acc [4]  = '{10, 300, -5, 77};
  int nom_exp [4]  = '{10, 255, 0, 77};
  int wrap_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    // reset state
    #2;
    chk("rst_valid", d_if.out_valid, 0);
    chk("rst_data", d_if.out_data, 0);
    chk("rst_addr", d_if.out_addr, 0);
    chk("rst_count", d_count, 0);
    chk("rst_flags", {d_fd, d_ovf, d_es}, 0);
    rst = 1'b1;
    tick();

    // nominal stream
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      taps(3);
      chk("nom_pre_valid", d_if.out_valid, 0);
      end_window(nom_acc[k]);
      chk("nom_valid", d_if.out_valid, 1);
      chk("nom_data", d_if.out_data, 32'(nom_exp[k]));
      chk("nom_addr", d_if.out_addr, 32'(k));
      idle();
    end
    chk("nom_err_short", d_es, 0);
    chk("nom_drained", d_count, 0);
    chk("nom_hold_data", d_if.out_data, 77);

    // backpressure with overflow
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      taps(3);
      end_window(k);
      if (k == 4) begin
        chk("bp_count4", d_count, 4);
        chk("bp_ovf4", d_ovf, 0);
      end
      if (k == 5) begin
        chk("bp_count5", d_count, 4);
        chk("bp_ovf5", d_ovf, 1);
      end
      idle();
    end
    chk("bp_head_stable", d_if.out_addr, 0);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_addr", d_if.out_addr, 32'(k));
      chk("bp_drain_data", d_if.out_data, 32'(k + 1));
      idle();
    end
    chk("bp_empty", d_count, 0);
    taps(3);
    end_window(9);
    chk("bp_next_addr", d_if.out_addr, 4);
    chk("bp_next_data", d_if.out_data, 9);

    // full with simultaneous pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      taps(3);
      end_window(11 + k);
    end
    chk("fp_full", d_count, 4);
    taps(3);
    ready = 1'b1;
    end_window(15);
    ready = 1'b0;
    chk("fp_count", d_count, 4);
    chk("fp_ovf", d_ovf, 0);
    chk("fp_head", d_if.out_addr, 1);
    ready = 1'b1;
    idle(); idle(); idle();
    chk("fp_tail_addr", d_if.out_addr, 4);
    chk("fp_tail_data", d_if.out_data, 15);

    // short window, clear, set-wins
    do_reset();
    ready = 1'b1;
    taps(2);
    end_window(50);
    chk("sh_count", d_count, 0);
    chk("sh_err", d_es, 1);
    sel = 2'b00; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sh_clr", d_es, 0);
    taps(1);
    clr_err = 1'b1;
    end_window(50);
    clr_err = 1'b0;
    chk("sh_set_wins", d_es, 1);
    taps(3);
    end_window(33);
    chk("sh_recover", d_if.out_data, 33);

    // frame wrap on the NUM_OUT=4 instance
    do_reset();
    ready = 1'b1;
    fd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      taps(3);
      end_window(20 + k);
      chk("wr_addr", w_if.out_addr, 32'(wrap_exp[k]));
      if (k == 3) chk("wr_fd_pulse", w_fd, 1);
      idle();
    end
    chk("wr_fd_once", 32'(fd_cnt), 1);

    // mid-operation reset
    do_reset();
    for (int k = 0; k < 2; k++) begin
      taps(3);
      end_window(5);
    end
    chk("mr_count", d_count, 2);
    rst = 1'b0;
    #1;
    chk("mr_valid", d_if.out_valid, 0);
    chk("mr_count0", d_count, 0);
    #2;
    rst = 1'b1;
    tick();

    // SHIFT=2 quantisation
    ready = 1'b1;
    taps(3);
    end_window(-1);
    chk("sf_neg_valid", s_if.out_valid, 1);
    chk("sf_neg", s_if.out_data, 0);
    idle();
    taps(3);
    end_window(1023);
    chk("sf_max", s_if.out_data, 255);
    idle();
    taps(3);
    end_window(1024);
    chk("sf_sat", s_if.out_data, 255);
    idle();
    taps(3);
    end_window(40);
    chk("sf_mid", s_if.out_data, 10);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
